t07_wire_cursor_ctrl: RTL

//  Parametrised cursor/cut controller for the wire mini-game. Tracks the selected wire among
//  up to MAX_WIRES and skips wires already cut. On SELECT, issues a cut request to the

---
 rtl/t07_game_pkg.sv | 24 ++
 rtl/t07_wire_uncut_search.sv | 61 ++++++
 rtl/t07_wire_cursor_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/t07_game_pkg.sv
// Shared game constants: playing modes, one-hot button codes and the wire cursor FSM states.
package t07_game_pkg;

  localparam logic [2:0] MODE_MENU = 3'b000;
  localparam logic [2:0] MODE_MOD  = 3'b001;
  localparam logic [2:0] MODE_WIRE = 3'b010;
  localparam logic [2:0] MODE_MAZE = 3'b011;
  localparam logic [2:0] MODE_LOST = 3'b100;
  localparam logic [2:0] MODE_WON  = 3'b101;

  localparam logic [5:0] BTN_SELECT = 6'b000001;
  localparam logic [5:0] BTN_UP     = 6'b000010;
  localparam logic [5:0] BTN_RIGHT  = 6'b000100;
  localparam logic [5:0] BTN_DOWN   = 6'b001000;
  localparam logic [5:0] BTN_LEFT   = 6'b010000;
  localparam logic [5:0] BTN_BACK   = 6'b100000;

  typedef logic [1:0] wire_state_t;
  localparam wire_state_t WS_IDLE = 2'd0;
  localparam wire_state_t WS_NAV  = 2'd1;
  localparam wire_state_t WS_CUT  = 2'd2;
  localparam wire_state_t WS_DONE = 2'd3;

endpackage

// File: rtl/t07_wire_uncut_search.sv
// Priority search over the cut mask: next/prev/lowest uncut wire below n, with optional wrap.
module t07_wire_uncut_search #(
  parameter  int MAX_WIRES = 8,
  localparam int POS_W     = $clog2(MAX_WIRES)
) (
  input  logic [MAX_WIRES-1:0] mask,
  input  logic [POS_W-1:0]     pos,
  input  logic [POS_W:0]       n,
  input  logic                 wrap,
  output logic [POS_W-1:0]     next_idx,
  output logic                 next_found,
  output logic [POS_W-1:0]     prev_idx,
  output logic                 prev_found,
  output logic [POS_W-1:0]     low_idx,
  output logic                 low_found
);

  logic [POS_W-1:0] high_idx;
  logic             high_found;

  always_comb begin
    next_idx   = '0;
    next_found = 1'b0;
    prev_idx   = '0;
    prev_found = 1'b0;
    low_idx    = '0;
    low_found  = 1'b0;
    high_idx   = '0;
    high_found = 1'b0;
    // descending scan: the last hit is the smallest qualifying index
    for (int i = MAX_WIRES - 1; i >= 0; i--) begin
      if (!mask[i] && i < int'(n)) begin
        low_idx   = POS_W'(i);
        low_found = 1'b1;
        if (i > int'(pos)) begin
          next_idx   = POS_W'(i);
          next_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < MAX_WIRES; i++) begin
      if (!mask[i] && i < int'(n)) begin
        high_idx   = POS_W'(i);
        high_found = 1'b1;
        if (i < int'(pos)) begin
          prev_idx   = POS_W'(i);
          prev_found = 1'b1;
        end
      end
    end
    if (wrap && !next_found) begin
      next_idx   = low_idx;
      next_found = low_found;
    end
    if (wrap && !prev_found) begin
      prev_idx   = high_idx;
      prev_found = high_found;
    end
  end

endmodule

// File: rtl/t07_wire_cursor_ctrl.sv
// Wire mini-game cursor/cut controller with req/ack cut handshake.
// Define WIRE_WRAP_EN to make RIGHT/LEFT wrap around the uncut wires instead of saturating.
module t07_wire_cursor_ctrl
  import t07_game_pkg::*;
#(
  parameter  int MAX_WIRES = 8,
  localparam int POS_W     = $clog2(MAX_WIRES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           playing_mode,
  input  logic                 strobe,
  input  logic [5:0]           button,
  input  logic [POS_W:0]       wire_num,
  input  logic                 cut_ack,
  output logic [POS_W-1:0]     wire_pos,
  output logic [MAX_WIRES-1:0] cut_mask,
  output logic                 cut_req,
  output logic [POS_W-1:0]     cut_idx,
  output logic                 cut_done,
  output logic                 all_cut
);

`ifdef WIRE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  localparam int             NW   = POS_W + 1;
  localparam logic [POS_W:0] MAXN = NW'(MAX_WIRES);

  wire_state_t            state;
  logic [POS_W:0]         n;
  logic                   in_wire;
  logic [MAX_WIRES-1:0]   srch_mask;
  logic                   srch_wrap;
  logic [POS_W-1:0]       nxt, prv, low;
  logic                   nxt_f, prv_f, low_f;

  assign in_wire = (playing_mode == MODE_WIRE);

  always_comb begin
    n = wire_num;
    if (wire_num == '0)       n = NW'(1);
    else if (wire_num > MAXN) n = MAXN;
  end

  // in CUT the search already treats the wire being cut as gone, so the
  // post-ack cursor move and the completion test see the updated mask
  assign srch_mask = (state == WS_CUT)
                   ? (cut_mask | ({{(MAX_WIRES-1){1'b0}}, 1'b1} << cut_idx))
                   : cut_mask;
  assign srch_wrap = WRAP && (state == WS_NAV);

  t07_wire_uncut_search #(.MAX_WIRES(MAX_WIRES)) u_search (
    .mask       (srch_mask),
    .pos        (wire_pos),
    .n          (n),
    .wrap       (srch_wrap),
    .next_idx   (nxt),
    .next_found (nxt_f),
    .prev_idx   (prv),
    .prev_found (prv_f),
    .low_idx    (low),
    .low_found  (low_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WS_IDLE;
      wire_pos <= '0;
      cut_mask <= '0;
      cut_req  <= 1'b0;
      cut_idx  <= '0;
      cut_done <= 1'b0;
      all_cut  <= 1'b0;
    end else begin
      cut_done <= 1'b0;
      if (!in_wire) begin
        state   <= WS_IDLE;
        cut_req <= 1'b0;
      end else begin
        case (state)
          WS_IDLE: begin
            state    <= WS_NAV;
            cut_mask <= '0;
            wire_pos <= '0;
            all_cut  <= 1'b0;
          end
          WS_NAV: begin
            if (!low_f) begin
              state   <= WS_DONE;
              all_cut <= 1'b1;
            end else if ({1'b0, wire_pos} >= n) begin
              wire_pos <= low;
            end else if (strobe) begin
              case (button)
                BTN_RIGHT:  if (nxt_f) wire_pos <= nxt;
                BTN_LEFT:   if (prv_f) wire_pos <= prv;
                BTN_BACK:   wire_pos <= low;
                BTN_SELECT: if (!cut_mask[wire_pos]) begin
                  state   <= WS_CUT;
                  cut_req <= 1'b1;
                  cut_idx <= wire_pos;
                end
                default: ;
              endcase
            end
          end
          WS_CUT: begin
            if (cut_ack) begin
              cut_req  <= 1'b0;
              cut_mask <= srch_mask;
              cut_done <= 1'b1;
              if (!low_f) begin
                state   <= WS_DONE;
                all_cut <= 1'b1;
              end else begin
                state    <= WS_NAV;
                wire_pos <= nxt_f ? nxt : prv;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
